// File: rtl/multicore_cache_sim_if.sv
// rtl/multicore_cache_sim_if.sv - trace request, response and counter bundle for the shared cache simulator
interface multicore_cache_sim_if #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 16,
    parameter int CNT_W     = 16,
    parameter int CORE_W    = 1
);
    logic [NUM_CORES-1:0]        req_valid;
    logic [NUM_CORES*ADDR_W-1:0] req_addr;
    logic [NUM_CORES-1:0]        req_ready;
    logic                        flush;
    logic                        busy;
    logic                        resp_valid;
    logic                        resp_hit;
    logic [CORE_W-1:0]           resp_core;
    logic [NUM_CORES*CNT_W-1:0]  hit_count;
    logic [NUM_CORES*CNT_W-1:0]  miss_count;

    modport master (
        output req_valid, req_addr, flush,
        input  req_ready, busy, resp_valid, resp_hit, resp_core, hit_count, miss_count
    );

    modport slave (
        input  req_valid, req_addr, flush,
        output req_ready, busy, resp_valid, resp_hit, resp_core, hit_count, miss_count
    );
endinterface

// File: rtl/multicore_cache_sim.sv
// rtl/multicore_cache_sim.sv - round-robin multi-core trace front end over a shared true-LRU set-associative tag store
module multicore_cache_sim #(
    parameter int NUM_CORES       = 2,
    parameter int ADDR_W          = 16,
    parameter int WAY             = 2,
    parameter int BLOCK_SIZE_BYTE = 4,
    parameter int CACHE_SIZE_BYTE = 16 * 1024,
    parameter int MISS_LATENCY    = 4,
    parameter int CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    multicore_cache_sim_if.slave bus
);
    localparam int SETS   = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY);
    localparam int OFF_W  = $clog2(BLOCK_SIZE_BYTE);
    localparam int SET_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - SET_W - OFF_W;
    localparam int AGE_W  = (WAY > 1) ? $clog2(WAY) : 1;
    localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int LAT_W  = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [CORE_W-1:0] cur_core;
    logic [CORE_W-1:0] rr;
    logic [LAT_W-1:0]  lat_cnt;
    logic [SET_W-1:0]  flush_idx;
    logic              resp_valid_q;
    logic              resp_hit_q;
    logic [CORE_W-1:0] resp_core_q;

    logic [TAG_W-1:0]  tag_mem   [SETS][WAY];
    logic              valid_mem [SETS][WAY];
    logic [AGE_W-1:0]  age_mem   [SETS][WAY];
    logic [CNT_W-1:0]  hit_cnt   [NUM_CORES];
    logic [CNT_W-1:0]  miss_cnt  [NUM_CORES];

    logic [SET_W-1:0]  set_idx;
    logic [TAG_W-1:0]  cur_tag;
    logic              grant_found;
    logic [CORE_W-1:0] grant_core;
    logic [CORE_W-1:0] cand;
    logic              hit;
    logic [AGE_W-1:0]  hit_way;
    logic              victim_found;
    logic [AGE_W-1:0]  victim;
    logic [AGE_W-1:0]  touch_way;
    logic [AGE_W-1:0]  old_age;

    assign set_idx = SET_W'(cur_addr >> OFF_W);
    assign cur_tag = TAG_W'(cur_addr >> (OFF_W + SET_W));

    // First requesting core at or after the round-robin pointer, cyclically.
    always_comb begin
        grant_found = 1'b0;
        grant_core  = '0;
        cand        = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = CORE_W'((int'(rr) + i) % NUM_CORES);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_core  = cand;
            end
        end
    end

    always_comb begin
        hit          = 1'b0;
        hit_way      = '0;
        victim_found = 1'b0;
        victim       = '0;
        for (int w = 0; w < WAY; w++) begin
            if (valid_mem[set_idx][w] && tag_mem[set_idx][w] == cur_tag) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
        for (int w = 0; w < WAY; w++) begin
            if (!victim_found && !valid_mem[set_idx][w]) begin
                victim_found = 1'b1;
                victim       = AGE_W'(w);
            end
        end
        if (!victim_found) begin
            for (int w = 0; w < WAY; w++) begin
                if (age_mem[set_idx][w] == AGE_W'(WAY - 1)) victim = AGE_W'(w);
            end
        end
        touch_way = (state == S_LOOKUP) ? hit_way : victim;
        old_age   = age_mem[set_idx][touch_way];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cur_addr     <= '0;
            cur_core     <= '0;
            rr           <= '0;
            lat_cnt      <= '0;
            flush_idx    <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_core_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAY; w++) begin
                    tag_mem[s][w]   <= '0;
                    valid_mem[s][w] <= 1'b0;
                    age_mem[s][w]   <= AGE_W'(w);
                end
            end
            for (int c = 0; c < NUM_CORES; c++) begin
                hit_cnt[c]  <= '0;
                miss_cnt[c] <= '0;
            end
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.flush) begin
                        flush_idx <= '0;
                        state     <= S_FLUSH;
                    end else if (grant_found) begin
                        cur_addr <= bus.req_addr[int'(grant_core)*ADDR_W +: ADDR_W];
                        cur_core <= grant_core;
                        rr       <= (int'(grant_core) == NUM_CORES - 1) ? '0 : grant_core + 1'b1;
                        state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        for (int w = 0; w < WAY; w++) begin
                            if (AGE_W'(w) == touch_way)           age_mem[set_idx][w] <= '0;
                            else if (age_mem[set_idx][w] < old_age) age_mem[set_idx][w] <= age_mem[set_idx][w] + 1'b1;
                        end
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b1;
                        resp_core_q  <= cur_core;
                        if (hit_cnt[cur_core] != '1) hit_cnt[cur_core] <= hit_cnt[cur_core] + 1'b1;
                        state <= S_IDLE;
                    end else begin
                        lat_cnt <= LAT_W'(MISS_LATENCY - 1);
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (lat_cnt == '0) state <= S_FILL;
                    else               lat_cnt <= lat_cnt - 1'b1;
                end
                S_FILL: begin
                    tag_mem[set_idx][victim]   <= cur_tag;
                    valid_mem[set_idx][victim] <= 1'b1;
                    for (int w = 0; w < WAY; w++) begin
                        if (AGE_W'(w) == touch_way)           age_mem[set_idx][w] <= '0;
                        else if (age_mem[set_idx][w] < old_age) age_mem[set_idx][w] <= age_mem[set_idx][w] + 1'b1;
                    end
                    resp_valid_q <= 1'b1;
                    resp_hit_q   <= 1'b0;
                    resp_core_q  <= cur_core;
                    if (miss_cnt[cur_core] != '1) miss_cnt[cur_core] <= miss_cnt[cur_core] + 1'b1;
                    state <= S_IDLE;
                end
                S_FLUSH: begin
                    for (int w = 0; w < WAY; w++) begin
                        valid_mem[flush_idx][w] <= 1'b0;
                        age_mem[flush_idx][w]   <= AGE_W'(w);
                    end
                    if (flush_idx == SET_W'(SETS - 1)) state <= S_IDLE;
                    else                               flush_idx <= flush_idx + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == S_IDLE && !bus.flush && grant_found)
                          ? (NUM_CORES'(1) << grant_core) : '0;
    assign bus.busy       = (state != S_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_hit   = resp_hit_q;
    assign bus.resp_core  = resp_core_q;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_cnt
        assign bus.hit_count[g*CNT_W +: CNT_W]  = hit_cnt[g];
        assign bus.miss_count[g*CNT_W +: CNT_W] = miss_cnt[g];
    end
endmodule

// File: tb/tb_multicore_cache_sim.sv
// tb/tb_multicore_cache_sim.sv - directed-vector bench for multicore_cache_sim
module tb_multicore_cache_sim;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    multicore_cache_sim_if #(.NUM_CORES(2), .ADDR_W(16), .CNT_W(4), .CORE_W(1)) bus ();

    multicore_cache_sim #(
        .NUM_CORES(2), .ADDR_W(16), .WAY(2), .BLOCK_SIZE_BYTE(4),
        .CACHE_SIZE_BYTE(16 * 1024), .MISS_LATENCY(4), .CNT_W(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] hits(input int c);
        return bus.hit_count[c*4 +: 4];
    endfunction

    function automatic logic [3:0] misses(input int c);
        return bus.miss_count[c*4 +: 4];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns latency in cycles from the accept edge to the cycle showing resp_valid.
    task automatic access(input int core, input logic [15:0] addr,
                          output int lat, output logic hit, output logic rc);
        int w;
        @(negedge clk);
        bus.req_valid[core]           = 1'b1;
        bus.req_addr[core*16 +: 16]   = addr;
        w = 0;
        #1;
        while (!bus.req_ready[core] && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 100) check_eq("accept_timeout", 32'(w), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[core] = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        hit = bus.resp_hit;
        rc  = bus.resp_core;
    endtask

    logic [15:0] t2_addr [7] = '{16'h0000, 16'h2000, 16'h0000, 16'h4000, 16'h2000, 16'h0000, 16'h2000};
    // Three tags share set 0 of a 2-way set: the final 0x0000 was evicted by 0x2000.
    logic        t2_hit  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int   lat;
        logic hit;
        logic rc;
        int   n;
        int   bad;
        int   seen;

        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rst_hit_count", 32'(bus.hit_count), 32'd0);
        check_eq("rst_miss_count", 32'(bus.miss_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", 32'(bus.req_ready), 32'd0);

        access(0, 16'h0000, lat, hit, rc);
        check_eq("t1_miss_lat", 32'(lat), 32'd7);
        check_eq("t1_miss_hit", 32'(hit), 32'd0);
        check_eq("t1_miss_core", 32'(rc), 32'd0);
        check_eq("t1_miss_cnt", 32'(misses(0)), 32'd1);
        access(0, 16'h0002, lat, hit, rc);
        check_eq("t1_hit_lat", 32'(lat), 32'd2);
        check_eq("t1_hit_hit", 32'(hit), 32'd1);
        check_eq("t1_hit_cnt", 32'(hits(0)), 32'd1);

        do_reset();
        for (int i = 0; i < 7; i++) begin
            access(0, t2_addr[i], lat, hit, rc);
            check_eq($sformatf("t2_hit_%0d", i), 32'(hit), 32'(t2_hit[i]));
            check_eq($sformatf("t2_lat_%0d", i), 32'(lat), t2_hit[i] ? 32'd2 : 32'd7);
        end
        check_eq("t2_hits", 32'(hits(0)), 32'd2);
        check_eq("t2_misses", 32'(misses(0)), 32'd5);

        do_reset();
        @(negedge clk);
        bus.req_addr  = {16'h0200, 16'h0100};
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            #1;
            while (bus.req_ready == 2'b00 && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
            check_eq($sformatf("t3_ready_%0d", i), 32'(bus.req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk);
            @(negedge clk);
            lat = 1;
            while (!bus.resp_valid && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            check_eq($sformatf("t3_core_%0d", i), 32'(bus.resp_core), 32'(i % 2));
        end
        bus.req_valid = 2'b00;

        @(negedge clk);
        bus.flush        = 1'b1;
        bus.req_valid[0] = 1'b1;
        bus.req_addr[15:0] = 16'h0100;
        #1;
        check_eq("t4_flush_beats_req", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        n   = 0;
        bad = 0;
        while (bus.busy && n < 3000) begin
            if (bus.req_ready != 2'b00) bad++;
            n++;
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        check_eq("t4_busy_cycles", 32'(n), 32'd2048);
        check_eq("t4_ready_while_busy", 32'(bad), 32'd0);
        access(0, 16'h0100, lat, hit, rc);
        check_eq("t4_post_flush_hit", 32'(hit), 32'd0);
        check_eq("t4_post_flush_lat", 32'(lat), 32'd7);
        check_eq("t4_hits0", 32'(hits(0)), 32'd1);
        check_eq("t4_misses0", 32'(misses(0)), 32'd2);
        check_eq("t4_hits1", 32'(hits(1)), 32'd1);
        check_eq("t4_misses1", 32'(misses(1)), 32'd1);

        do_reset();
        access(1, 16'h0300, lat, hit, rc);
        check_eq("t5_first_core", 32'(rc), 32'd1);
        for (int i = 0; i < 20; i++) access(1, 16'h0300, lat, hit, rc);
        check_eq("t5_last_hit", 32'(hit), 32'd1);
        check_eq("t5_hits1_sat", 32'(hits(1)), 32'd15);
        check_eq("t5_misses1", 32'(misses(1)), 32'd1);
        check_eq("t5_hits0", 32'(hits(0)), 32'd0);
        check_eq("t5_misses0", 32'(misses(0)), 32'd0);

        do_reset();
        access(0, 16'h0500, lat, hit, rc);
        check_eq("t6_pre_miss", 32'(misses(0)), 32'd1);
        @(negedge clk);
        bus.req_valid[0]   = 1'b1;
        bus.req_addr[15:0] = 16'h0400;
        n = 0;
        #1;
        while (!bus.req_ready[0] && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        check_eq("t6_busy_in_fetch", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("t6_async_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check_eq("t6_no_resp", 32'(seen), 32'd0);
        check_eq("t6_busy", 32'(bus.busy), 32'd0);
        check_eq("t6_counters", 32'({bus.hit_count, bus.miss_count}), 32'd0);
        access(0, 16'h0400, lat, hit, rc);
        check_eq("t6_same_addr_miss", 32'(hit), 32'd0);
        check_eq("t6_same_addr_lat", 32'(lat), 32'd7);
        access(0, 16'h0500, lat, hit, rc);
        check_eq("t6_old_line_gone", 32'(hit), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end
endmodule
